// File: rtl/crd_pkg.sv
// Shared definitions for the multi-lane running-disparity checker.
package crd_pkg;

   // Same encoding as the existing CRD block's idle/pos/neg states.
   typedef enum logic [1:0] {
      RD_UNK = 2'b00,
      RD_POS = 2'b01,
      RD_NEG = 2'b10
   } rd_state_t;

   // Widest symbol the popcount helper accepts.
   localparam int unsigned POPCNT_MAX_W = 64;

   // Number of ones in the low 'width' bits of v.
   function automatic int unsigned popcount(input logic [POPCNT_MAX_W-1:0] v,
                                            input int unsigned             width);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < POPCNT_MAX_W; i++) begin
         if (i < width && v[i]) n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/crd_lane.sv
// Single-lane running-disparity tracker: symbol balance check, 3-state RD FSM
// and a saturating error counter.
module crd_lane
   import crd_pkg::*;
#(
   parameter int unsigned SYM_W     = 10,
   parameter int unsigned CNT_W     = 8,
   parameter int          INIT_MODE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sym_valid,
   input  logic [SYM_W-1:0] sym,
   input  logic             rd_resync,
   input  logic             clr_cnt,
   output logic             rd_out,
   output logic             rd_known,
   output logic             disp_err,
   output logic             sym_err,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int unsigned H       = SYM_W / 2;
   localparam rd_state_t   INIT_ST = (INIT_MODE != 0) ? RD_NEG : RD_UNK;

   rd_state_t   state_q, state_d, cur_st, eval_st;
   int unsigned ones;
   logic        d_err, s_err, err;

   // Evaluate the symbol against the current (or resync'd) RD and pick the next state.
   always_comb begin
      cur_st  = rd_resync ? INIT_ST : state_q;
      ones    = popcount(POPCNT_MAX_W'(sym), SYM_W);
      eval_st = cur_st;
      d_err   = 1'b0;
      s_err   = 1'b0;
      if (ones == H + 1) begin
         eval_st = RD_POS;
         d_err   = (cur_st == RD_POS);
      end else if (ones == H - 1) begin
         eval_st = RD_NEG;
         d_err   = (cur_st == RD_NEG);
      end else if (ones != H) begin
         s_err   = 1'b1;
      end
      state_d = state_q;
      if (sym_valid)      state_d = eval_st;
      else if (rd_resync) state_d = INIT_ST;
   end

   assign err = sym_valid & (d_err | s_err);

   // RD state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= INIT_ST;
      else     state_q <= state_d;
   end

   // Per-symbol error flags, only raised for valid symbols.
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_err <= 1'b0;
         sym_err  <= 1'b0;
      end else begin
         disp_err <= sym_valid & d_err;
         sym_err  <= sym_valid & s_err;
      end
   end

   // Saturating error counter; a clear in the same cycle as an error leaves 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (clr_cnt) begin
         err_cnt <= err ? CNT_W'(1) : '0;
      end else if (err && err_cnt != '1) begin
         err_cnt <= err_cnt + CNT_W'(1);
      end
   end

   assign rd_out   = (state_q == RD_POS);
   assign rd_known = (state_q != RD_UNK);

endmodule

// File: rtl/crd_multilane_checker.sv
// Multi-lane running-disparity checker: one crd_lane per lane plus shared
// result-valid and error-summary outputs.
module crd_multilane_checker
   import crd_pkg::*;
#(
   parameter int unsigned LANES     = 4,
   parameter int unsigned SYM_W     = 10,
   parameter int unsigned CNT_W     = 8,
   parameter int          INIT_MODE = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sym_valid,
   input  logic [LANES*SYM_W-1:0] sym_in,
   input  logic                   rd_resync,
   input  logic                   clr_cnt,
   output logic                   out_valid,
   output logic [LANES-1:0]       rd_out,
   output logic [LANES-1:0]       rd_known,
   output logic [LANES-1:0]       disp_err,
   output logic [LANES-1:0]       sym_err,
   output logic [LANES*CNT_W-1:0] err_cnt,
   output logic                   any_err
);

   for (genvar n = 0; n < LANES; n++) begin : g_lane
      crd_lane #(
         .SYM_W     (SYM_W),
         .CNT_W     (CNT_W),
         .INIT_MODE (INIT_MODE)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .sym_valid (sym_valid),
         .sym       (sym_in[n*SYM_W +: SYM_W]),
         .rd_resync (rd_resync),
         .clr_cnt   (clr_cnt),
         .rd_out    (rd_out[n]),
         .rd_known  (rd_known[n]),
         .disp_err  (disp_err[n]),
         .sym_err   (sym_err[n]),
         .err_cnt   (err_cnt[n*CNT_W +: CNT_W])
      );
   end

   // Result valid follows the sampled sym_valid by one cycle.
   always_ff @(posedge clk) begin
      if (rst) out_valid <= 1'b0;
      else     out_valid <= sym_valid;
   end

   // Error summary is an OR of the registered per-lane flags, so it shares their timing.
   assign any_err = |{disp_err, sym_err};

endmodule

// File: tb/tb_crd_multilane_checker.sv
// Scoreboard bench for crd_multilane_checker: DUT A (INIT_MODE=1, CNT_W=2)
// and DUT B (INIT_MODE=0, CNT_W=8), both SYM_W=10, LANES=4.
module tb_crd_multilane_checker;

   typedef struct packed {
      logic [3:0]  rd;
      logic [3:0]  kn;
      logic [3:0]  de;
      logic [3:0]  se;
      logic [31:0] cnt;
      logic        any;
   } exp_t;

   localparam logic [9:0] SP = 10'h0FC; // 6 ones
   localparam logic [9:0] SZ = 10'h01F; // 5 ones
   localparam logic [9:0] SN = 10'h00F; // 4 ones
   localparam logic [9:0] SX = 10'h3FF; // 10 ones
   localparam logic [9:0] S0 = 10'h000; // 0 ones

   int n_tests = 0;
   int n_fail  = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst = 1'b1, a_v = 1'b0, a_rs = 1'b0, a_cl = 1'b0;
   logic [39:0] a_sym = '0;
   logic        a_ov, a_any;
   logic [3:0]  a_rd, a_kn, a_de, a_se;
   logic [7:0]  a_cnt;

   logic        b_rst = 1'b1, b_v = 1'b0, b_rs = 1'b0, b_cl = 1'b0;
   logic [39:0] b_sym = '0;
   logic        b_ov, b_any;
   logic [3:0]  b_rd, b_kn, b_de, b_se;
   logic [31:0] b_cnt;

   crd_multilane_checker #(.LANES(4), .SYM_W(10), .CNT_W(2), .INIT_MODE(1)) dut_a (
      .clk(clk), .rst(a_rst), .sym_valid(a_v), .sym_in(a_sym), .rd_resync(a_rs),
      .clr_cnt(a_cl), .out_valid(a_ov), .rd_out(a_rd), .rd_known(a_kn),
      .disp_err(a_de), .sym_err(a_se), .err_cnt(a_cnt), .any_err(a_any));

   crd_multilane_checker #(.LANES(4), .SYM_W(10), .CNT_W(8), .INIT_MODE(0)) dut_b (
      .clk(clk), .rst(b_rst), .sym_valid(b_v), .sym_in(b_sym), .rd_resync(b_rs),
      .clr_cnt(b_cl), .out_valid(b_ov), .rd_out(b_rd), .rd_known(b_kn),
      .disp_err(b_de), .sym_err(b_se), .err_cnt(b_cnt), .any_err(b_any));

   exp_t a_got, b_got;
   assign a_got = {a_rd, a_kn, a_de, a_se, {24'h0, a_cnt}, a_any};
   assign b_got = {b_rd, b_kn, b_de, b_se, b_cnt, b_any};

   exp_t  qa[$], qb[$];
   string qa_name[$], qb_name[$];

   function automatic exp_t mk(input logic [3:0] rd, kn, de, se,
                               input logic [31:0] cnt, input logic any);
      exp_t e;
      e = {rd, kn, de, se, cnt, any};
      return e;
   endfunction

   task automatic report(input string name, input logic gov, input exp_t g,
                         input logic eov, input exp_t e);
      n_tests++;
      if (gov !== eov || g !== e) begin
         n_fail++;
         $display("FAIL %s: got ov=%b rd=%b kn=%b de=%b se=%b cnt=%h any=%b, expected ov=%b rd=%b kn=%b de=%b se=%b cnt=%h any=%b",
                  name, gov, g.rd, g.kn, g.de, g.se, g.cnt, g.any,
                  eov, e.rd, e.kn, e.de, e.se, e.cnt, e.any);
      end
   endtask

   // Monitors: pop and compare whenever a DUT presents a result.
   always @(negedge clk) begin
      if (a_ov) begin
         if (qa.size() == 0) report("a_unexpected", a_ov, a_got, 1'b0, a_got);
         else report(qa_name.pop_front(), a_ov, a_got, 1'b1, qa.pop_front());
      end
      if (b_ov) begin
         if (qb.size() == 0) report("b_unexpected", b_ov, b_got, 1'b0, b_got);
         else report(qb_name.pop_front(), b_ov, b_got, 1'b1, qb.pop_front());
      end
   end

   task automatic step_a(input string name, input logic r, v, rs, cl,
                         input logic [39:0] s, input exp_t e);
      a_rst = r; a_v = v; a_rs = rs; a_cl = cl; a_sym = s;
      if (v && !r) begin
         qa.push_back(e);
         qa_name.push_back(name);
      end
      @(posedge clk); #1;
   endtask

   task automatic step_b(input string name, input logic r, v, rs, cl,
                         input logic [39:0] s, input exp_t e);
      b_rst = r; b_v = v; b_rs = rs; b_cl = cl; b_sym = s;
      if (v && !r) begin
         qb.push_back(e);
         qb_name.push_back(name);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t nul;
      nul = '0;
      // Reset both DUTs
      step_a("a_rst0", 1, 0, 0, 0, '0, nul);
      step_a("a_rst1", 1, 0, 0, 0, '0, nul);
      report("a_reset", a_ov, a_got, 1'b0, mk(4'h0, 4'hF, 4'h0, 4'h0, 32'h0, 1'b0));
      report("b_reset", b_ov, b_got, 1'b0, mk(4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0));

      // DUT A: all lanes start NEG
      step_a("a_t1_lane0_pos", 0, 1, 0, 0, {SZ, SZ, SZ, SP}, mk(4'b0001, 4'hF, 4'h0, 4'h0, 32'h00, 1'b0));
      step_a("a_t2_lane1_pos", 0, 1, 0, 0, {SZ, SZ, SP, SZ}, mk(4'b0011, 4'hF, 4'h0, 4'h0, 32'h00, 1'b0));
      step_a("a_t2_lane1_disp", 0, 1, 0, 0, {SZ, SZ, SP, SZ}, mk(4'b0011, 4'hF, 4'b0010, 4'h0, 32'h04, 1'b1));
      step_a("a_t3_lane2_sym", 0, 1, 0, 0, {SZ, SX, SZ, SZ}, mk(4'b0011, 4'hF, 4'h0, 4'b0100, 32'h14, 1'b1));
      step_a("a_t4_sat1", 0, 1, 0, 0, {SX, SZ, SZ, SZ}, mk(4'b0011, 4'hF, 4'h0, 4'b1000, 32'h54, 1'b1));
      step_a("a_t4_sat2", 0, 1, 0, 0, {SX, SZ, SZ, SZ}, mk(4'b0011, 4'hF, 4'h0, 4'b1000, 32'h94, 1'b1));
      step_a("a_t4_sat3", 0, 1, 0, 0, {SX, SZ, SZ, SZ}, mk(4'b0011, 4'hF, 4'h0, 4'b1000, 32'hD4, 1'b1));
      step_a("a_t4_sat4", 0, 1, 0, 0, {SX, SZ, SZ, SZ}, mk(4'b0011, 4'hF, 4'h0, 4'b1000, 32'hD4, 1'b1));
      step_a("a_t4_sat5", 0, 1, 0, 0, {SX, SZ, SZ, SZ}, mk(4'b0011, 4'hF, 4'h0, 4'b1000, 32'hD4, 1'b1));
      step_a("a_t4_clr_err", 0, 1, 0, 1, {SX, SZ, SZ, SZ}, mk(4'b0011, 4'hF, 4'h0, 4'b1000, 32'h40, 1'b1));
      step_a("a_lane3_neg_disp", 0, 1, 0, 0, {SN, SZ, SZ, SZ}, mk(4'b0011, 4'hF, 4'b1000, 4'h0, 32'h80, 1'b1));

      // Idle cycles: garbage symbols must be ignored and RD held
      for (int i = 0; i < 3; i++) begin
         step_a("a_idle", 0, 0, 0, 0, {SX, SX, SX, SX}, nul);
         report("a_idle_hold", a_ov, a_got, 1'b0, mk(4'b0011, 4'hF, 4'h0, 4'h0, 32'h80, 1'b0));
      end

      // Resync together with a symbol: lanes 0/1 (currently POS) judged against NEG
      step_a("a_resync_valid", 0, 1, 1, 0, {SZ, SZ, SP, SP}, mk(4'b0011, 4'hF, 4'h0, 4'h0, 32'h80, 1'b0));
      step_a("a_resync_idle", 0, 0, 1, 0, '0, nul);
      report("a_resync_idle", a_ov, a_got, 1'b0, mk(4'b0000, 4'hF, 4'h0, 4'h0, 32'h80, 1'b0));

      // Reset during a valid symbol discards it
      step_a("a_rst_mid", 1, 1, 0, 0, {SX, SX, SX, SX}, nul);
      report("a_rst_mid", a_ov, a_got, 1'b0, mk(4'h0, 4'hF, 4'h0, 4'h0, 32'h0, 1'b0));
      step_a("a_post_rst_disp", 0, 1, 0, 0, {SZ, SZ, SZ, SN}, mk(4'b0000, 4'hF, 4'b0001, 4'h0, 32'h01, 1'b1));
      step_a("a_end", 0, 0, 0, 0, '0, nul);

      // DUT B: all lanes start UNK
      step_b("b_rst", 1, 0, 0, 0, '0, nul);
      step_b("b_neutral_unk", 0, 1, 0, 0, {SZ, SZ, SZ, SZ}, mk(4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0));
      step_b("b_learn_neg", 0, 1, 0, 0, {SZ, SZ, SZ, SN}, mk(4'h0, 4'b0001, 4'h0, 4'h0, 32'h0, 1'b0));
      step_b("b_learn_pos", 0, 1, 0, 0, {SZ, SZ, SP, SZ}, mk(4'b0010, 4'b0011, 4'h0, 4'h0, 32'h0, 1'b0));
      step_b("b_lane0_disp", 0, 1, 0, 0, {SZ, SZ, SZ, SN}, mk(4'b0010, 4'b0011, 4'b0001, 4'h0, 32'h1, 1'b1));
      step_b("b_resync_neg", 0, 1, 1, 0, {SZ, SZ, SZ, SN}, mk(4'h0, 4'b0001, 4'h0, 4'h0, 32'h1, 1'b0));
      step_b("b_relearn_pos", 0, 1, 0, 0, {SZ, SZ, SP, SZ}, mk(4'b0010, 4'b0011, 4'h0, 4'h0, 32'h1, 1'b0));
      step_b("b_zero_sym", 0, 1, 0, 0, {SZ, S0, SZ, SZ}, mk(4'b0010, 4'b0011, 4'h0, 4'b0100, 32'h00010001, 1'b1));
      step_b("b_end", 0, 0, 0, 0, '0, nul);
      repeat (3) @(posedge clk);
      #1;

      n_tests++;
      if (qa.size() != 0) begin
         n_fail++;
         $display("FAIL a_drain: got %0d pending results, expected 0", qa.size());
      end
      n_tests++;
      if (qb.size() != 0) begin
         n_fail++;
         $display("FAIL b_drain: got %0d pending results, expected 0", qb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/crd_multilane_checker.md
Name: crd_multilane_checker

Overview:
- Multi-lane running-disparity (RD) checker for 8b/10b-coded PCIe symbol streams.
- Successor to the single-lane 10-bit CRD block: parametrised lane count and symbol width, and a selectable initial-RD mode.
- Adds valid-qualified input, separate symbol-balance and disparity errors, per-lane saturating error counters and RD resync.
- Sits after lane deskew and before the 8b/10b decoder; its error outputs feed the receiver error log.

Parameters:
- LANES, 4, number of independent lanes.
- SYM_W, 10, symbol width in bits; must be even and >= 4.
- CNT_W, 8, width of each per-lane error counter.
- INIT_MODE, 1, initial RD after reset/resync: 1 = negative (PCIe rule), 0 = unknown, learned from the first unbalanced symbol.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- sym_valid  in  1  sym_in carries one symbol per lane this cycle.
- sym_in  in  LANES*SYM_W  lane n at bits [n*SYM_W +: SYM_W].
- rd_resync  in  1  return every lane to the initial RD state.
- clr_cnt  in  1  clear all error counters.
- out_valid  out  1  result valid, one cycle after the sampled sym_valid.
- rd_out  out  LANES  RD after the symbol; 1 = positive, 0 = negative or unknown.
- rd_known  out  LANES  1 when the lane's RD is POS or NEG.
- disp_err  out  LANES  disparity violation on this symbol.
- sym_err  out  LANES  symbol imbalance beyond ±1 one.
- err_cnt  out  LANES*CNT_W  per-lane saturating error count.
- any_err  out  1  OR of all disp_err and sym_err bits.

Behaviour:
- Reset (rst=1 at an edge):
  - Each lane state = NEG if INIT_MODE=1, else UNK.
  - out_valid, disp_err, sym_err, any_err = 0.
  - err_cnt = 0.
  - rd_out = 0; rd_known = INIT_MODE.
  - rst overrides every other input.
- Latency: one cycle. Popcount and next-state logic are combinational from sym_in; all outputs are registered.
- Per-lane states: UNK, POS, NEG. Let H = SYM_W/2, ones = popcount(lane symbol).
- ones == H: neutral. State unchanged (UNK stays UNK), no error.
- ones == H+1: next state POS.
  - disp_err=1 if the current state is POS, else 0.
  - After an error the state is still POS (resynchronise on the symbol).
- ones == H-1: next state NEG; disp_err=1 if the current state is NEG.
- Any other ones count: sym_err=1, disp_err=0, state unchanged.
- sym_valid=0: state and rd_out held; out_valid, disp_err, sym_err, any_err = 0 next cycle; counters unchanged.
- rd_resync with sym_valid=0: all lanes go to the initial state.
- rd_resync with sym_valid=1: the symbol is evaluated against the initial state, not the current one.
- err_cnt[n]:
  - Increments by 1 on a valid symbol with disp_err|sym_err.
  - Saturates at 2^CNT_W-1 with no wrap.
  - clr_cnt zeroes it; clr_cnt and an error in the same cycle give 1.
- Lanes are fully independent; no cross-lane interaction apart from any_err.
- rst asserted mid-stream: the next-cycle outputs equal the reset values; the symbol sampled in that cycle is discarded.

Decomposition:
- Shared package crd_pkg:
  - RD state encoding RD_UNK=2'b00, RD_POS=2'b01, RD_NEG=2'b10 (same encoding as the existing CRD block's idle/pos/neg).
  - A popcount function sized by SYM_W.
- One natural sub-module, crd_lane: popcount, 3-state FSM and saturating counter for a single lane.
- Top level: generate loop of LANES instances, plus the out_valid/any_err registers.

Test Plan (SYM_W=10, LANES=4):
1. INIT_MODE=1, reset, lane0 = 10'h0FC (6 ones), other lanes 10'h01F (5 ones) → next cycle out_valid=1, rd_out=4'b0001, rd_known=4'hF, no errors.
2. Lane1 receives 10'h0FC on two consecutive valid cycles → second result disp_err=4'b0010, rd_out[1]=1, err_cnt lane1=1, any_err=1.
3. Lane2 = 10'h3FF (10 ones) → sym_err=4'b0100, disp_err=0, rd_out[2] unchanged, err_cnt lane2 increments.
4. CNT_W=2, five consecutive error symbols on lane3 → err_cnt lane3 = 3 (saturated). Then clr_cnt plus an error in the same cycle → 1.
5. INIT_MODE=0 → rd_known=0 after reset. 10'h01F keeps the lane UNK; 10'h00F (4 ones) gives NEG with no error. rd_resync together with 10'h00F gives NEG with no error (evaluated against UNK).
6. sym_valid low for 3 cycles mid-stream → out_valid=0 and rd_out held. Then rst during a valid symbol → all outputs at reset values next cycle and counters 0.
